// File: rtl/sort_pkg.sv
// Shared types and constants for the sorter host-side sequencer.
//   sort_ctrl_state_t : controller phases LOAD -> START -> SORT -> READ -> DRAIN
//   SORT_CYC_W        : width of the saturating SORT-phase cycle counter
//   job_size()        : number of words in one job (2^L)
package sort_pkg;

    typedef enum logic [2:0] {
        LOAD,
        START,
        SORT,
        READ,
        DRAIN
    } sort_ctrl_state_t;

    localparam int SORT_CYC_W = 16;

    function automatic int job_size(input int l);
        return 1 << l;
    endfunction

endpackage

// File: rtl/sort_out_fifo.sv
// Small synchronous FIFO that buffers words read back from the sorter.
//   clk, rst    : clock, synchronous active-high reset (empties the FIFO)
//   push        : write push_data this cycle (ignored when full and not popping)
//   push_data   : {last flag, data word}
//   pop         : drop the head entry this cycle (ignored when empty)
//   head        : current head entry, valid while !empty
//   empty       : FIFO holds no entries
//   count       : number of entries held
// Simultaneous push and pop leaves the occupancy unchanged.
module sort_out_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 9,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = bump(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = bump(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/sort_stream_ctrl.sv
// Host-side sequencer for the sorting engine.
//   clk, rst          : clock, synchronous active-high reset (all outputs 0 while rst=1)
//   s_valid/s_data/s_ready : input stream, exactly 2^L words per job
//   m_valid/m_data/m_last/m_ready : sorted output stream, m_last on address 2^L-1
//   srt_WrInit/srt_RAddr/srt_DataIn : sorter initial-load write port
//   srt_Rd/srt_DataOut : sorter read port, data valid RD_LAT cycles after srt_Rd
//   srt_start/srt_done : sorter start pulse and done level
//   busy              : high whenever the controller is not in LOAD
//   sort_cycles       : cycles spent in SORT for the last job, saturating
module sort_stream_ctrl
    import sort_pkg::*;
#(
    parameter int N      = 8,
    parameter int L      = 4,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [N-1:0]          s_data,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [N-1:0]          m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  srt_WrInit,
    output logic [L-1:0]          srt_RAddr,
    output logic [N-1:0]          srt_DataIn,
    output logic                  srt_Rd,
    output logic                  srt_start,
    input  logic [N-1:0]          srt_DataOut,
    input  logic                  srt_done,
    output logic                  busy,
    output logic [SORT_CYC_W-1:0] sort_cycles
);

    localparam int             CW        = L + 1;
    localparam int             FIFO_D    = RD_LAT + 1;
    localparam int             CNT_W     = $clog2(FIFO_D + 1);
    localparam logic [CW-1:0]  LAST_ADDR = CW'(job_size(L) - 1);

    sort_ctrl_state_t        state_q, state_d;
    logic [CW-1:0]           wcnt_q, wcnt_d;
    logic [CW-1:0]           rcnt_q, rcnt_d;
    logic [SORT_CYC_W-1:0]   sort_cycles_q, sort_cycles_d;
    // One bit per pipeline stage of the sorter read path: a read is in flight, and it is the last one.
    logic [RD_LAT-1:0]       inflight_q, inflight_d;
    logic [RD_LAT-1:0]       inflast_q, inflast_d;

    logic                    s_ready_c, wr_c, rd_c, start_c;
    logic [L-1:0]            raddr_c;
    logic [N-1:0]            din_c;
    logic [7:0]              outstanding;
    logic                    credit_ok;

    logic [N:0]              fifo_head;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        rcnt_d        = rcnt_q;
        sort_cycles_d = sort_cycles_q;
        s_ready_c     = 1'b0;
        wr_c          = 1'b0;
        rd_c          = 1'b0;
        start_c       = 1'b0;
        raddr_c       = '0;
        din_c         = '0;

        // Every issued read owns a FIFO slot until its word leaves, so the FIFO can never overflow.
        outstanding = 8'(fifo_count);
        for (int i = 0; i < RD_LAT; i++) begin
            outstanding = outstanding + 8'(inflight_q[i]);
        end
        credit_ok = (outstanding < 8'(RD_LAT + 1));

        case (state_q)
            LOAD: begin
                s_ready_c = 1'b1;
                if (s_valid) begin
                    wr_c    = 1'b1;
                    raddr_c = wcnt_q[L-1:0];
                    din_c   = s_data;
                    wcnt_d  = wcnt_q + CW'(1);
                    if (wcnt_q == LAST_ADDR) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                start_c       = 1'b1;
                sort_cycles_d = '0;
                state_d       = SORT;
            end
            SORT: begin
                if (sort_cycles_q != '1) begin
                    sort_cycles_d = sort_cycles_q + SORT_CYC_W'(1);
                end
                // sort_cycles_q is still 0 only in the first SORT cycle; done there is a stale level.
                if ((sort_cycles_q != '0) && srt_done) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (credit_ok) begin
                    rd_c    = 1'b1;
                    raddr_c = rcnt_q[L-1:0];
                    rcnt_d  = rcnt_q + CW'(1);
                    if (rcnt_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty && (inflight_q == '0)) begin
                    state_d = LOAD;
                    wcnt_d  = '0;
                    rcnt_d  = '0;
                end
            end
            default: state_d = LOAD;
        endcase

        inflight_d[0] = rd_c;
        inflast_d[0]  = rd_c && (rcnt_q == LAST_ADDR);
        for (int i = 1; i < RD_LAT; i++) begin
            inflight_d[i] = inflight_q[i-1];
            inflast_d[i]  = inflast_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= LOAD;
            wcnt_q        <= '0;
            rcnt_q        <= '0;
            sort_cycles_q <= '0;
            inflight_q    <= '0;
            inflast_q     <= '0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            rcnt_q        <= rcnt_d;
            sort_cycles_q <= sort_cycles_d;
            inflight_q    <= inflight_d;
            inflast_q     <= inflast_d;
        end
    end

    // The oldest pipeline stage lines up with valid srt_DataOut.
    sort_out_fifo #(
        .DEPTH (FIFO_D),
        .W     (N + 1),
        .CNT_W (CNT_W)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q[RD_LAT-1]),
        .push_data ({inflast_q[RD_LAT-1], srt_DataOut}),
        .pop       (m_valid && m_ready),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // All outputs are forced low while reset is asserted, whatever the pre-reset state.
    assign s_ready     = s_ready_c && !rst;
    assign m_valid     = !fifo_empty && !rst;
    assign m_data      = rst ? '0 : fifo_head[N-1:0];
    assign m_last      = fifo_head[N] && !rst;
    assign srt_WrInit  = wr_c && !rst;
    assign srt_Rd      = rd_c && !rst;
    assign srt_RAddr   = rst ? '0 : raddr_c;
    assign srt_DataIn  = rst ? '0 : din_c;
    assign srt_start   = start_c && !rst;
    assign busy        = (state_q != LOAD) && !rst;
    assign sort_cycles = rst ? '0 : sort_cycles_q;

endmodule

// File: tb/tb_sort_stream_ctrl.sv
// Self-checking bench for sort_stream_ctrl with a behavioural sorter model.
// Expected output of each job is the ascending sort of the words loaded.
module tb_sort_stream_ctrl #(
    parameter int RD_LAT = 1
);

    localparam int N   = 8;
    localparam int L   = 4;
    localparam int JOB = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_ready;
    logic        srt_WrInit;
    logic [3:0]  srt_RAddr;
    logic [7:0]  srt_DataIn;
    logic        srt_Rd;
    logic        srt_start;
    logic [7:0]  srt_DataOut;
    logic        srt_done;
    logic        busy;
    logic [15:0] sort_cycles;

    always #5 clk = ~clk;

    sort_stream_ctrl #(.N(N), .L(L), .RD_LAT(RD_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .srt_WrInit  (srt_WrInit),
        .srt_RAddr   (srt_RAddr),
        .srt_DataIn  (srt_DataIn),
        .srt_Rd      (srt_Rd),
        .srt_start   (srt_start),
        .srt_DataOut (srt_DataOut),
        .srt_done    (srt_done),
        .busy        (busy),
        .sort_cycles (sort_cycles)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural sorter ----------------
    logic [7:0] smem    [JOB];
    logic [7:0] rd_pipe [RD_LAT];
    logic [7:0] tmp     [JOB];
    int         hist    [256];
    int         k;
    bit         done_r, sorting, stale_en;
    int         scnt, sort_delay;

    assign srt_DataOut = rd_pipe[RD_LAT-1];
    assign srt_done    = done_r;

    always @(posedge clk) begin
        if (rst) begin
            done_r  <= 1'b0;
            sorting <= 1'b0;
            scnt    <= 0;
        end else begin
            if (srt_WrInit) smem[srt_RAddr] <= srt_DataIn;
            if (srt_start) begin
                for (int v = 0; v < 256; v++) hist[v] = 0;
                for (int i = 0; i < JOB; i++) hist[smem[i]]++;
                k = 0;
                for (int v = 0; v < 256; v++)
                    for (int c = 0; c < hist[v]; c++) begin
                        tmp[k] = 8'(v);
                        k++;
                    end
                for (int i = 0; i < JOB; i++) smem[i] <= tmp[i];
                sorting <= 1'b1;
                scnt    <= sort_delay;
                if (!stale_en) done_r <= 1'b0;
            end else if (sorting) begin
                if (scnt <= 1) begin
                    done_r  <= 1'b1;
                    sorting <= 1'b0;
                end else begin
                    scnt   <= scnt - 1;
                    done_r <= 1'b0;
                end
            end
        end
        rd_pipe[0] <= srt_Rd ? smem[srt_RAddr] : 8'($urandom);
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // ---------------- downstream ready driver ----------------
    int mr_mode = 0;
    int mr_cnt  = 0;
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mr_cnt++;
            case (mr_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((mr_cnt % 4) == 0) || ((mr_cnt % 4) == 3);
                default: m_ready = 1'($urandom_range(1));
            endcase
        end
    end

    // ---------------- monitor (samples on falling edge) ----------------
    logic [7:0] job_w [JOB];
    logic [7:0] exp_q [$];
    int         cyc, acc_cnt, rd_cnt, hs_cnt, start_cyc, sort_obs;
    bit         in_job, prev_stall, prev_start, prev_acc, loading;
    logic [8:0] held;

    initial begin
        cyc = 0; acc_cnt = 0; rd_cnt = 0; hs_cnt = 0; start_cyc = 0; sort_obs = -1;
        in_job = 0; prev_stall = 0; prev_start = 0; prev_acc = 0; held = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                check("rst_outputs", {s_ready, m_valid, m_data, m_last, srt_WrInit, srt_RAddr,
                      srt_DataIn, srt_Rd, srt_start, busy, sort_cycles}, 64'd0);
                acc_cnt = 0; rd_cnt = 0; hs_cnt = 0;
                in_job = 0; prev_stall = 0; prev_start = 0; prev_acc = 0;
            end else begin
                check("strobe_excl", srt_WrInit && srt_Rd, 0);
                if (!srt_WrInit && !srt_Rd) check("idle_pins", {srt_RAddr, srt_DataIn}, 0);
                check("wrinit_hs", srt_WrInit, loading && s_valid && (acc_cnt < JOB));
                if (loading && acc_cnt < JOB) check("s_ready_load", s_ready, 1);
                if (srt_WrInit) begin
                    check("wr_addr", srt_RAddr, 64'(acc_cnt));
                    check("wr_data", srt_DataIn, s_data);
                    acc_cnt++;
                end
                if (srt_start) begin
                    check("start_timing", {prev_start, prev_acc, 8'(acc_cnt)}, {1'b0, 1'b1, 8'(JOB)});
                    in_job    = 1;
                    start_cyc = cyc;
                end
                if (srt_Rd) begin
                    check("rd_in_job", in_job, 1);
                    check("rd_addr", srt_RAddr, 64'(rd_cnt));
                    if (rd_cnt == 0) sort_obs = cyc - start_cyc - 1;
                    rd_cnt++;
                end
                if (in_job) begin
                    check("busy_phase", {s_ready, busy}, 2'b01);
                    check("credit", (rd_cnt - hs_cnt) <= RD_LAT + 1, 1);
                end else begin
                    check("idle_mvalid", m_valid, 0);
                end
                if (prev_stall) check("stall_hold", {m_valid, m_last, m_data}, {1'b1, held});
                if (m_valid && m_ready) begin
                    if (hs_cnt < JOB && hs_cnt < exp_q.size()) begin
                        check("out_word", {m_last, m_data}, {hs_cnt == JOB - 1, exp_q[hs_cnt]});
                    end else begin
                        check("extra_word", 1, 0);
                    end
                    hs_cnt++;
                    if (hs_cnt == JOB) in_job = 0;
                end
                prev_stall = m_valid && !m_ready;
                held       = {m_last, m_data};
                prev_start = srt_start;
                prev_acc   = srt_WrInit;
            end
        end
    end

    // ---------------- stimulus tasks (called at posedge+1) ----------------
    task automatic load_job(input int gap, input int delay, input bit stale);
        int  i, guard;
        bit  hs;
        sort_delay = delay;
        stale_en   = stale;
        exp_q      = {};
        for (int j = 0; j < JOB; j++) exp_q.push_back(job_w[j]);
        exp_q.sort();
        acc_cnt = 0; rd_cnt = 0; hs_cnt = 0; sort_obs = -1;
        loading = 1;
        i = 0; guard = 0;
        while (i < JOB && guard < 1000) begin
            s_valid = ($urandom_range(99) >= gap);
            s_data  = job_w[i];
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (hs) i++;
            guard++;
        end
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        loading = 0;
        check("load_done", i, JOB);
    endtask

    task automatic wait_out(input int n);
        int guard = 0;
        while (hs_cnt < n && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("out_count", hs_cnt, n);
    endtask

    task automatic finish_job(input int delay);
        wait_out(JOB);
        for (int j = 0; j < 6 && busy; j++) begin
            @(posedge clk);
            #1;
        end
        check("busy_fall", busy, 0);
        check("s_ready_idle", s_ready, 1);
        check("sort_obs", sort_obs, delay + 1);
        check("sort_cycles", sort_cycles, 64'(sort_obs));
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst", {busy, m_valid, s_ready}, 3'b001);
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int gap, input int mode, input int delay, input bit stale);
        mr_mode = mode;
        load_job(gap, delay, stale);
        finish_job(delay);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; loading = 0;
        stale_en = 0; sort_delay = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", {busy, m_valid, s_ready, sort_cycles}, {1'b0, 1'b0, 1'b1, 16'd0});
        @(posedge clk);
        #1;

        // descending load, free-flowing output
        for (int i = 0; i < JOB; i++) job_w[i] = 8'(15 - i);
        run_job(0, 0, 3, 0);
        // same job, stalled output, done still high from the previous job
        run_job(0, 1, 1, 1);
        // random data with input gaps and random output stalls
        for (int i = 0; i < JOB; i++) job_w[i] = 8'($urandom);
        run_job(50, 2, 4, 1);
        // all-equal words
        for (int i = 0; i < JOB; i++) job_w[i] = 8'hA5;
        run_job(0, 0, 2, 0);
        // extremes and duplicates
        for (int i = 0; i < JOB; i++)
            case ($urandom_range(3))
                0:       job_w[i] = 8'h00;
                1:       job_w[i] = 8'hFF;
                2:       job_w[i] = 8'h80;
                default: job_w[i] = 8'h01;
            endcase
        run_job(20, 2, 6, 1);

        // reset during SORT
        for (int i = 0; i < JOB; i++) job_w[i] = 8'($urandom);
        mr_mode = 0;
        load_job(0, 40, 0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        pulse_rst();
        // reset during READ with words still outstanding
        load_job(0, 2, 0);
        wait_out(11);
        pulse_rst();
        for (int i = 0; i < JOB; i++) job_w[i] = 8'($urandom);
        run_job(30, 1, 5, 0);

        // a few more random jobs
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < JOB; i++) job_w[i] = 8'($urandom_range(15));
            d = int'($urandom_range(25)) + 1;
            run_job(int'($urandom_range(70)), int'($urandom_range(2)), d, 1'($urandom_range(1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sort_stream_ctrl.md
Name: sort_stream_ctrl

Overview:
Host-side sequencer for the sorting engine. It accepts exactly 2^L words on a valid/ready input stream and writes them into the sorter's register file. It then pulses the sorter's start, waits for done, and reads the sorted array back out on a valid/ready output stream. It sits between the system streaming fabric and the sorter's WrInit/RAddr/DataIn/Rd/DataOut/start/done pins, and owns those pins exclusively.

Parameters:
N, 8, data word width (matches sorter N)
L, 4, address width; job size is 2^L words
RD_LAT, 1, sorter read latency in cycles from Rd/RAddr to valid DataOut (1 or 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
s_valid  in  1  input word valid
s_data  in  N  input word
s_ready  out  1  controller accepts input word
m_valid  out  1  sorted output word valid
m_data  out  N  sorted output word
m_last  out  1  marks word read from address 2^L-1
m_ready  in  1  downstream accepts output word
srt_WrInit  out  1  sorter initial-load write strobe
srt_RAddr  out  L  sorter load/read address
srt_DataIn  out  N  sorter load data
srt_Rd  out  1  sorter read strobe
srt_start  out  1  sorter start pulse
srt_DataOut  in  N  sorter read data
srt_done  in  1  sorter done level
busy  out  1  high whenever state != LOAD
sort_cycles  out  16  cycles spent in SORT for the last job, saturating

Behaviour:
- Single clock `clk`; `rst` is synchronous, active-high. All state is reset on the clk edge where rst=1.
- Reset values: state=LOAD, wcnt=rcnt=0, FIFO empty, in-flight=0, sort_cycles=0. While rst=1, every output is 0, including s_ready.
- States: LOAD, START, SORT, READ, DRAIN.
- LOAD:
  - s_ready=1.
  - On s_valid&&s_ready: srt_WrInit=1, srt_RAddr=wcnt, srt_DataIn=s_data, all combinational in the same cycle. Then wcnt++.
  - Accepting word 2^L-1 moves to START.
  - Gaps in s_valid produce no write.
- START: srt_start=1 for exactly this one cycle; s_ready=0; sort_cycles cleared to 0; go to SORT.
- SORT:
  - sort_cycles increments each cycle and saturates at 16'hFFFF.
  - srt_done is ignored in the first SORT cycle, which masks a stale level left over from the previous job.
  - From the second SORT cycle onward, srt_done=1 moves to READ.
  - There is no timeout.
- READ:
  - Issue a read (srt_Rd=1, srt_RAddr=rcnt, rcnt++) only when FIFO occupancy + reads in flight < RD_LAT+1.
  - srt_DataOut is captured into the FIFO exactly RD_LAT cycles after the issuing cycle.
  - After the read of address 2^L-1 is issued, go to DRAIN.
- DRAIN: stay until the FIFO is empty and no read is in flight, i.e. the m_last word has handshaken. Then go to LOAD with wcnt=rcnt=0.
- Output stream:
  - m_valid = FIFO not empty; m_data/m_last = FIFO head.
  - While m_valid && !m_ready, m_data and m_last hold stable.
  - Words leave in address order 0..2^L-1. m_last=1 only on the word read from address 2^L-1.
- Sorter pin rules:
  - srt_WrInit and srt_Rd are never high in the same cycle.
  - srt_RAddr=0 and srt_DataIn=0 when neither strobe is active.
  - srt_start is high only in START.
- Counters: wcnt and rcnt are L+1 bits wide, so the terminal count is detected without wrap ambiguity.
- sort_cycles holds its value from the end of SORT until the next START.
- Reset mid-operation (any state): return to LOAD immediately and discard FIFO contents and in-flight reads. m_valid=0 in the first cycle after reset. The sorter shares the same rst and is not separately commanded.
- Simultaneous FIFO push and pop in one cycle is legal; occupancy is unchanged.

Decomposition:
- Package sort_pkg:
  - state enum sort_ctrl_state_t {LOAD, START, SORT, READ, DRAIN}
  - constant SORT_CYC_W=16
  - function for job size 2^L
- Sub-module sort_out_fifo: synchronous FIFO of depth RD_LAT+1, width N+1 (data plus last flag), with push/pop/count and synchronous reset. It is the only natural split; the FSM, counters and credit logic stay in the top.

Test Plan:
1. Load 16 words 15,14,...,0 (N=8, L=4) with continuous s_valid and m_ready=1 -> 16 WrInit pulses at addresses 0..15; srt_start high exactly one cycle, the cycle after the 16th accept; output 0..15 in order; m_last only on 15; busy falls after the last handshake.
2. Same job with m_ready pattern 1,0,0,1 repeating -> output still 0..15 with no loss or duplication; m_data stable on every stalled cycle; never more than 2 words buffered or in flight.
3. Random s_valid gaps (~50% duty) during load -> WrInit only on handshake cycles; addresses strictly consecutive 0..15; s_ready=0 from START until the next LOAD.
4. Data all 8'hA5, then a mix of 8'h00/8'hFF/duplicates -> output equals the sorted multiset; srt_done held high from the previous job does not end SORT early (first-cycle mask); sort_cycles > 0 and matches cycles counted by the bench.
5. Assert rst for 1 cycle during SORT, then again during READ with 5 words outstanding -> state LOAD, m_valid=0, s_ready=1 the cycle after rst drops; the following full job produces correct sorted output.
6. Rebuild with RD_LAT=2 and rerun scenarios 1–2 -> identical output sequences; FIFO depth 3 never overflows; srt_Rd never issued when credit is exhausted.
